// File: rtl/mem_pkg.sv
// Shared constants and types for byte_mem_responder and its TX FIFO.
// The IO region exists only when IO_MAP_EN is defined.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] IO_BASE_DEF      = 32'h0003_0000;
  localparam logic [ADDR_W-1:0] STATUS_OFS_FLAGS = 32'd0;
  localparam logic [ADDR_W-1:0] STATUS_OFS_COUNT = 32'd4;

  localparam int unsigned TX_DEPTH_DEF = 4;

  // Source of the byte travelling down the read pipeline.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_RAM,
    RD_IO
  } rd_src_e;

endpackage

// File: rtl/byte_mem_responder_io_tx_fifo.sv
// io_tx_fifo: power-of-two depth FIFO with occupancy/full/empty, used as the
// transmit queue of the IO region (only instantiated with IO_MAP_EN).
module io_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/byte_mem_responder.sv
// byte_mem_responder: byte-wide RAM with a two-cycle read pipeline and,
// when IO_MAP_EN is defined, an IO region holding a TX FIFO and status reads.
module byte_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 17,
  parameter logic [ADDR_W-1:0] IO_BASE    = IO_BASE_DEF,
  parameter int unsigned       TX_DEPTH   = TX_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [BYTE_W-1:0] mem_write_byte_i,
  output logic [BYTE_W-1:0] mem_read_byte_o,
  output logic              mem_read_valid_o,
  output logic              mem_stall_o,
  output logic [BYTE_W-1:0] io_tx_data_o,
  output logic              io_tx_valid_o,
  input  logic              io_tx_ready_i
);

  logic [BYTE_W-1:0] ram [2**ADDR_WIDTH];

  logic                  accept;
  logic                  is_io;
  logic [BYTE_W-1:0]     io_rd_byte;
  rd_src_e               src1;
  rd_src_e               src2;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [BYTE_W-1:0]     io1;
  logic [BYTE_W-1:0]     io2;
  logic [BYTE_W-1:0]     ram_rd;

`ifdef IO_MAP_EN
  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic              tx_hit;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;
  logic [BYTE_W-1:0] tx_head;

  assign is_io  = (mem_addr_i >= IO_BASE);
  assign tx_hit = (mem_addr_i == IO_BASE);
  // Stall uses start-of-cycle fullness, so a same-cycle dequeue does not release it.
  assign mem_stall_o = mem_ce_i & mem_we_i & tx_hit & tx_full;
  assign accept      = mem_ce_i & ~mem_stall_o;

  // Status byte selected at acceptance time.
  always_comb begin
    io_rd_byte = '0;
    if (mem_addr_i == IO_BASE + STATUS_OFS_FLAGS)
      io_rd_byte = {{(BYTE_W-1){1'b0}}, tx_full};
    else if (mem_addr_i == IO_BASE + STATUS_OFS_COUNT)
      io_rd_byte = BYTE_W'(tx_count);
  end

  io_tx_fifo #(
    .DEPTH(TX_DEPTH),
    .WIDTH(BYTE_W)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & mem_we_i & tx_hit),
    .push_data (mem_write_byte_i),
    .pop       (io_tx_ready_i),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign io_tx_valid_o = ~tx_empty;
  assign io_tx_data_o  = tx_head;
`else
  logic unused_cfg;

  assign is_io         = 1'b0;
  assign mem_stall_o   = 1'b0;
  assign accept        = mem_ce_i;
  assign io_rd_byte    = '0;
  assign io_tx_valid_o = 1'b0;
  assign io_tx_data_o  = '0;
  assign unused_cfg    = ^{mem_addr_i[ADDR_W-1:ADDR_WIDTH], io_tx_ready_i,
                           IO_BASE, 32'(TX_DEPTH)};
`endif

  // Read pipeline valid/source tracking; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src1 <= RD_NONE;
      src2 <= RD_NONE;
    end else begin
      if (accept && !mem_we_i) src1 <= is_io ? RD_IO : RD_RAM;
      else                     src1 <= RD_NONE;
      src2 <= src1;
    end
  end

  // RAM write commit, RAM read in stage 2, and data path registers (no reset).
  always_ff @(posedge clk) begin
    if (accept && mem_we_i && !is_io)
      ram[mem_addr_i[ADDR_WIDTH-1:0]] <= mem_write_byte_i;
    addr1  <= mem_addr_i[ADDR_WIDTH-1:0];
    io1    <= io_rd_byte;
    io2    <= io1;
    ram_rd <= ram[addr1];
  end

  // Result mux; byte is forced to zero whenever no read result is present.
  always_comb begin
    mem_read_valid_o = 1'b0;
    mem_read_byte_o  = '0;
    case (src2)
      RD_RAM: begin
        mem_read_valid_o = 1'b1;
        mem_read_byte_o  = ram_rd;
      end
      RD_IO: begin
        mem_read_valid_o = 1'b1;
        mem_read_byte_o  = io2;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/byte_mem_responder.md
BYTE_MEM_RESPONDER -- requirements
Module: byte_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, sets the RAM region to 2^ADDR_WIDTH bytes.
REQ-002 Parameter IO_BASE, default 32'h0003_0000, is the first address of the IO region.
REQ-003 Parameter TX_DEPTH, default 4, sets the IO transmit FIFO depth in entries (power of two).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 mem_ce_i  in  1  request valid for this cycle.
REQ-007 mem_we_i  in  1  1 = write byte, 0 = read byte.
REQ-008 mem_addr_i  in  32  byte address.
REQ-009 mem_write_byte_i  in  8  write data.
REQ-010 mem_read_byte_o  out  8  read data.
REQ-011 mem_read_valid_o  out  1  mem_read_byte_o carries a valid read.
REQ-012 mem_stall_o  out  1  request not accepted this cycle; requester holds all inputs.
REQ-013 io_tx_data_o  out  8  transmit byte.
REQ-014 io_tx_valid_o  out  1  io_tx_data_o valid.
REQ-015 io_tx_ready_i  in  1  consumer accepts the byte when valid and ready are both high.

Function
REQ-016 Requests are accepted when mem_ce_i=1 and mem_stall_o=0; one byte per accepted request.
REQ-017 Addresses below IO_BASE map to RAM, indexed by mem_addr_i[ADDR_WIDTH-1:0]; upper bits are ignored (wrap-around).
REQ-018 A read accepted in cycle N drives mem_read_byte_o and mem_read_valid_o=1 in cycle N+2; back-to-back reads sustain one result per cycle.
REQ-019 A RAM write accepted in cycle N commits at the end of cycle N; a read of the same address accepted in cycle N+1 returns the new byte.
REQ-020 Cycles with no accepted read produce mem_read_valid_o=0 two cycles later; mem_read_byte_o is then 8'h00.
REQ-021 An IO write to IO_BASE enqueues mem_write_byte_i into the TX FIFO; IO writes to other IO addresses are discarded.
REQ-022 An IO read of IO_BASE returns {7'b0, fifo_full}; an IO read of IO_BASE+4 returns the FIFO occupancy; other IO reads return 8'h00. The read latency is the same as for RAM.
REQ-023 mem_stall_o = mem_ce_i & mem_we_i & (IO write to IO_BASE) & fifo_full; this term is combinational and is evaluated against the occupancy at the start of the cycle, so it stays asserted even when a dequeue occurs in the same cycle.
REQ-024 The FIFO head is presented on io_tx_data_o with io_tx_valid_o=!empty; a dequeue occurs when io_tx_valid_o & io_tx_ready_i.
REQ-025 A simultaneous enqueue and dequeue on a non-empty, non-full FIFO leaves the occupancy unchanged and preserves order.

Reset
REQ-026 While rst=0 at a clock edge: read pipeline valids clear, FIFO pointers and occupancy clear, and mem_read_valid_o, mem_read_byte_o, io_tx_valid_o and mem_stall_o are 0 in the following cycle.
REQ-027 Reset does not clear RAM contents; in-flight reads are dropped and not replayed.

Configuration
REQ-028 Macro IO_MAP_EN: when defined, the IO region, TX FIFO and status reads exist as specified.
REQ-029 Without IO_MAP_EN, all addresses map to RAM, io_tx_valid_o is tied 0, io_tx_data_o is tied 8'h00, and mem_stall_o is tied 0.

Structure
REQ-030 A shared package mem_pkg holds IO_BASE, the status offsets (0, 4), the TX_DEPTH default and the byte/address width constants.
REQ-031 The TX FIFO is the sub-module io_tx_fifo, which provides occupancy, full and empty outputs.

Verification
REQ-032 Write 8'hA5 to address 0x100 in cycle 0, then read 0x100 in cycle 1 -> mem_read_byte_o=8'hA5 with valid in cycle 3.
REQ-033 Reads of 0x0, 0x1, 0x2, 0x3 in cycles 0-3 after pre-loading 11,22,33,44 -> the bytes appear in order in cycles 2-5 with valid held continuously.
REQ-034 Write 8'h7E to 0x0002_0005 with ADDR_WIDTH=17 -> a read of 0x0000_0005 returns 8'h7E.
REQ-035 With io_tx_ready_i=0, issue five IO writes to IO_BASE -> the fifth write sees mem_stall_o=1. Then raise ready for one cycle -> the fifth write is accepted in the following cycle and the output order is byte1..byte5.
REQ-036 With three bytes queued, read IO_BASE+4 -> 8'h03 two cycles later, and a read of IO_BASE -> 8'h00.
REQ-037 Assert rst=0 for one cycle between a read acceptance and its result -> mem_read_valid_o stays 0, the FIFO is empty, and RAM data written before reset reads back unchanged.
